// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio output path:
//   state_e    - serializer state encoding (ST_IDLE, ST_RUN)
//   LEFT_LSB   - bit position of the left channel in a 32-bit stereo beat
//   RIGHT_LSB  - bit position of the right channel in a 32-bit stereo beat
//   clog2()    - ceiling log2, used to size FIFO pointers and counters
// ---------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int LEFT_LSB  = 0;
    localparam int RIGHT_LSB = 16;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous show-ahead FIFO: rdata_o always presents the oldest entry while
// empty_o is low, and pop_i simply advances past it.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset (flushes pointers)
//   push_i, wdata_i write strobe and data (caller guarantees !full_o)
//   pop_i           advance read pointer (caller guarantees !empty_o)
//   rdata_o         head-of-queue data
//   full_o, empty_o occupancy flags
// DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge aclk) begin
        // NOTE: clocked state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of process order.
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, so a flush only needs the pointers.
    always_ff @(posedge aclk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/axis_i2s_tx.sv
// ---------------------------------------------------------------------------
// axis_i2s_tx
// AXI-Stream to Philips I2S serializer. Stereo beats ([15:0] left,
// [31:16] right) are buffered in a sample_fifo and shifted out MSB first with
// a one-bit delay after each LRCLK transition. BCLK/LRCLK/SDATA are registered
// outputs in the aclk domain, derived from an integer divider.
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   tx_en                run enable, checked at start and at each frame wrap
//   s_axis_*             AXI-Stream sink (tlast accepted and ignored)
//   i2s_bclk/lrclk/sdata I2S bit clock, word select (1 = right), data
//   underrun             one-cycle pulse when a frame starts with FIFO empty
// Build option:
//   I2S_TX_HOLD_LAST_EN  on underrun repeat the last popped sample instead
//                        of sending silence
// ---------------------------------------------------------------------------
module axis_i2s_tx
    import audio_pkg::*;
#(
    parameter int AUDIO_WIDTH = 16,
    parameter int BCLK_DIV    = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        tx_en,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underrun
);

    localparam int FW = 2 * AUDIO_WIDTH;
    localparam int BW = clog2(FW);
    localparam int DW = clog2(BCLK_DIV);

    state_e          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic [FW-1:0]   last_q, last_d;
    logic            bclk_q, bclk_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic            underrun_q, underrun_d;
    logic            rst_done_q;

    logic            push, pop, fifo_full, fifo_empty;
    logic [31:0]     fifo_rdata;
    logic [FW-1:0]   fifo_frame, underrun_fill;
    logic            tick, fall, wrap, start;
    logic            unused_tlast;

    assign unused_tlast = s_axis_tlast;

    // tready stays low while reset is held and for the reset edge itself.
    assign s_axis_tready = rst_done_q && !fifo_full;
    assign push          = s_axis_tvalid && s_axis_tready;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push_i  (push),
        .wdata_i (s_axis_tdata),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Shift order is {left, right} so the left MSB leaves first.
    assign fifo_frame = {fifo_rdata[LEFT_LSB +: AUDIO_WIDTH],
                         fifo_rdata[RIGHT_LSB +: AUDIO_WIDTH]};

`ifdef I2S_TX_HOLD_LAST_EN
    assign underrun_fill = last_q;
`else
    // last_q is kept in this build too so both share one reset behaviour.
    logic unused_last;
    assign unused_last   = ^last_q;
    assign underrun_fill = '0;
`endif

    assign tick  = (div_cnt_q == DW'(BCLK_DIV - 1));
    assign fall  = tick && bclk_q;
    assign wrap  = fall && (bit_cnt_q == BW'(FW - 1));
    assign start = (state_q == ST_IDLE) && tx_en && !fifo_empty;

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: a stop request only takes effect at a frame wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)          state_d = ST_RUN;
            ST_RUN:  if (wrap && !tx_en) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next-state logic.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                if (start) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_frame;
                    last_d    = fifo_frame;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                end else if (sdata_q) begin
                    // The final right LSB is held for one more half-period
                    // after the stopping wrap, then sdata parks at 0.
                    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
                    if (tick) sdata_d = 1'b0;
                end else begin
                    div_cnt_d = '0;
                end
            end
            ST_RUN: begin
                div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
                if (tick) bclk_d = !bclk_q;
                if (fall) begin
                    sdata_d = shreg_q[FW-1];
                    if (wrap) begin
                        bit_cnt_d = '0;
                        lrclk_d   = 1'b0;
                        if (tx_en) begin
                            if (!fifo_empty) begin
                                pop     = 1'b1;
                                shreg_d = fifo_frame;
                                last_d  = fifo_frame;
                            end else begin
                                underrun_d = 1'b1;
                                shreg_d    = underrun_fill;
                            end
                        end
                    end else begin
                        shreg_d   = {shreg_q[FW-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (int'(bit_cnt_q) + 1 == AUDIO_WIDTH) lrclk_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            last_q     <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            rst_done_q <= 1'b1;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_axis_i2s_tx
// Directed bench for axis_i2s_tx (AUDIO_WIDTH=16, BCLK_DIV=4, FIFO_DEPTH=4).
// Each accepted beat pushes its expected 32-bit serial frame into exp_q; a
// monitor reassembles frames from sdata at BCLK falling edges and compares
// them, together with BCLK period, LRCLK pattern and frame period.
// Honours I2S_TX_HOLD_LAST_EN for the expected underrun frame content.
// ---------------------------------------------------------------------------
module tb_axis_i2s_tx;

    localparam int AW    = 16;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 2 * AW * 2 * DIV;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        tx_en = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata, underrun;

    axis_i2s_tx #(
        .AUDIO_WIDTH (AW),
        .BCLK_DIV    (DIV),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .tx_en         (tx_en),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .i2s_bclk      (i2s_bclk),
        .i2s_lrclk     (i2s_lrclk),
        .i2s_sdata     (i2s_sdata),
        .underrun      (underrun)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          push_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        prev_bclk = 1'b0, prev_lr = 1'b0, prev_sdata = 1'b0;
    int          idx = 0, falls = 0, frames = 0, und_cnt = 0;
    int          last_fall_cyc = 0, last_wrap_cyc = -1;
    bit          frame_cont = 1'b0;
    logic [31:0] word = '0, lrpat = '0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            idx = 0; word = '0; lrpat = '0; last_wrap_cyc = -1; frame_cont = 1'b0;
            prev_bclk = 1'b0; prev_lr = 1'b0; prev_sdata = 1'b0;
        end else begin
            if (underrun) und_cnt++;
            if (prev_bclk && !i2s_bclk) begin
                if (idx == 0) frame_cont = (falls > 0) && (cyc - last_fall_cyc == 2 * DIV);
                else          check("bclk_period", cyc - last_fall_cyc, 2 * DIV);
                last_fall_cyc = cyc;
                falls++;
                idx++;
                word  = {word[30:0], i2s_sdata};
                lrpat = {lrpat[30:0], i2s_lrclk};
                if (prev_lr && !i2s_lrclk) begin
                    check("frame_len", idx, 32);
                    check("lrclk_pattern", lrpat, 32'h0001_FFFE);
                    if (exp_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL frame_data: got unexpected frame 0x%0h, expected none", word);
                    end else begin
                        check("frame_data", word, exp_q.pop_front());
                    end
                    if (frame_cont && last_wrap_cyc >= 0)
                        check("frame_period", cyc - last_wrap_cyc, FRAME);
                    last_wrap_cyc = cyc;
                    frames++;
                    idx = 0; word = '0; lrpat = '0;
                end
            end else if (!prev_bclk && i2s_bclk) begin
                check("sdata_stable_at_rise", i2s_sdata, prev_sdata);
                check("lrclk_stable_at_rise", i2s_lrclk, prev_lr);
            end
            prev_bclk  = i2s_bclk;
            prev_lr    = i2s_lrclk;
            prev_sdata = i2s_sdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    function automatic logic [31:0] frame_of(input logic [31:0] d);
        return {d[15:0], d[31:16]};
    endfunction

    task automatic push(input logic [31:0] d);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = d[0];
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 2000) begin step(); n++; end
        if (!s_axis_tready) begin
            n_checks++; n_errors++;
            $display("FAIL push_timeout: tready stayed 0, expected 1");
        end else begin
            @(posedge aclk);
            #1;
            push_cyc = cyc;
            exp_q.push_back(frame_of(d));
        end
        step();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 4000) begin step(); n++; end
        if (frames < target) begin
            n_checks++; n_errors++;
            $display("FAIL frame_timeout: frames %0d, expected %0d", frames, target);
        end
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (idx != k && n < 4000) begin step(); n++; end
        if (idx != k) begin
            n_checks++; n_errors++;
            $display("FAIL bit_timeout: bit index %0d, expected %0d", idx, k);
        end
    endtask

    // Called on the negedge right after the stopping wrap.
    task automatic check_stop(input logic lsb);
        int f0;
        check("stop_sdata_lsb", i2s_sdata, lsb);
        repeat (2) step();
        check("stop_sdata_held", i2s_sdata, lsb);
        repeat (4) step();
        check("stop_sdata_zero", i2s_sdata, 0);
        check("stop_bclk_zero", i2s_bclk, 0);
        check("stop_lrclk_zero", i2s_lrclk, 0);
        f0 = falls;
        repeat (16) step();
        check("stop_clocks_parked", falls, f0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] d, fill;
        int          fr0, u0, f0, e;

        // Reset state
        repeat (3) step();
        check("rst_tready", s_axis_tready, 0);
        check("rst_bclk", i2s_bclk, 0);
        check("rst_lrclk", i2s_lrclk, 0);
        check("rst_sdata", i2s_sdata, 0);
        check("rst_underrun", underrun, 0);
        aresetn = 1'b1;
        step();
        check("tready_after_reset", s_axis_tready, 1);

        // Single sample, first-bit latency, stop before the wrap
        fr0 = frames; u0 = und_cnt; f0 = falls;
        tx_en = 1'b1;
        push(32'hA5A5_1234);
        e = push_cyc;
        while (falls == f0 && cyc < e + 100) step();
        check("first_msb_latency", last_fall_cyc, e + 9);
        tx_en = 1'b0;
        wait_frames(fr0 + 1);
        check_stop(1'b1);
        check("single_no_underrun", und_cnt - u0, 0);

        // Ramp of 8 samples streamed continuously
        fr0 = frames; u0 = und_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) tx_en = 1'b1;
            push({16'h8000 + 16'(i), 16'h1111 * 16'(i + 1)});
        end
        wait_frames(fr0 + 7);
        tx_en = 1'b0;
        wait_frames(fr0 + 8);
        check_stop(1'b1);
        check("ramp_no_underrun", und_cnt - u0, 0);

        // Backpressure: 6 beats against a 4-deep FIFO while idle
        fr0 = frames; u0 = und_cnt;
        for (int i = 0; i < 4; i++) push({16'h0F00 + 16'(i), 16'hC000 + 16'(i)});
        check("tready_low_when_full", s_axis_tready, 0);
        s_axis_tdata  = 32'h0F04_C004;
        s_axis_tvalid = 1'b1;
        repeat (3) step();
        check("tready_stays_low_idle", s_axis_tready, 0);
        tx_en = 1'b1;
        step();
        check("tready_after_pop", s_axis_tready, 1);
        push(32'h0F04_C004);
        push(32'h0F05_C005);
        wait_frames(fr0 + 5);
        tx_en = 1'b0;
        wait_frames(fr0 + 6);
        check_stop(1'b1);
        check("bp_no_underrun", und_cnt - u0, 0);

        // Underrun: one sample then an empty FIFO for two more frames
        fr0 = frames; u0 = und_cnt;
        d = 32'h0003_C00F;
        tx_en = 1'b1;
        push(d);
`ifdef I2S_TX_HOLD_LAST_EN
        fill = frame_of(d);
`else
        fill = 32'h0;
`endif
        exp_q.push_back(fill);
        exp_q.push_back(fill);
        wait_frames(fr0 + 2);
        tx_en = 1'b0;
        wait_frames(fr0 + 3);
        check_stop(fill[0]);
        check("underrun_pulses", und_cnt - u0, 2);

        // tx_en dropped at bit 10: frame completes, one sample left behind
        fr0 = frames; u0 = und_cnt;
        push(32'h1357_2468);
        push(32'h0001_7FFE);
        tx_en = 1'b1;
        wait_idx(10);
        tx_en = 1'b0;
        wait_frames(fr0 + 1);
        check_stop(1'b1);
        tx_en = 1'b1;
        wait_idx(1);
        tx_en = 1'b0;
        wait_frames(fr0 + 2);
        check_stop(1'b1);
        check("drop_no_underrun", und_cnt - u0, 0);

        // Reset mid-frame: outputs clear next cycle, FIFO flushed
        tx_en = 1'b1;
        push(32'hFFFF_FFFF);
        push(32'h7777_8888);
        wait_idx(5);
        aresetn = 1'b0;
        exp_q.delete();
        step();
        check("midrst_bclk", i2s_bclk, 0);
        check("midrst_lrclk", i2s_lrclk, 0);
        check("midrst_sdata", i2s_sdata, 0);
        check("midrst_tready", s_axis_tready, 0);
        step();
        aresetn = 1'b1;
        step();
        check("midrst_tready_release", s_axis_tready, 1);
        f0 = falls;
        repeat (40) step();
        check("midrst_fifo_flushed", falls, f0);
        check("midrst_bclk_idle", i2s_bclk, 0);
        tx_en = 1'b0;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_i2s_tx.md
# axis_i2s_tx

AXI-Stream to I2S serializer. It sits directly downstream of the stereo gain stage: it buffers 32-bit stereo PCM beats in a small FIFO and shifts them out as a standard Philips I2S stream (BCLK, LRCLK, SDATA) to the audio DAC. All outputs are generated in the aclk domain from an integer clock divider.

## Interface
- AUDIO_WIDTH, 16: bits per channel; frame = 2*AUDIO_WIDTH BCLK periods.
- BCLK_DIV, 4: aclk cycles per BCLK half-period; must be ≥2.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of two, ≥2.

Ports (clock and reset first):
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- tx_en  in  1  transmit enable; level, sampled per the state machine below.
- s_axis_tdata  in  32  [15:0] left, [31:16] right, two's complement.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  high when the FIFO is not full.
- s_axis_tlast  in  1  accepted and ignored.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- underrun  out  1  one-aclk pulse when a frame starts with the FIFO empty.

## Operation
- Reset values: s_axis_tready 0 during reset and 1 after; i2s_bclk 0, i2s_lrclk 0, i2s_sdata 0, underrun 0. FIFO empty, state IDLE.
- FIFO push: s_axis_tvalid && s_axis_tready.
- A push and a pop in the same cycle are both legal. A push and a pop in the same cycle while full cannot occur, because tready is low when full.
- State machine:
  - IDLE → RUN when tx_en && FIFO not empty. On that cycle: pop into a 2*AUDIO_WIDTH shift register ({left, right}, left MSB first); bit_cnt=0, div_cnt=0, bclk=0, lrclk=0.
  - RUN → IDLE at a frame wrap when tx_en=0. No pop on that wrap. The last right LSB is still driven on sdata at that wrap. Outputs then hold bclk=0, lrclk=0, and sdata holds 0 from the next falling-edge slot onward (forced 0 one half-period later).
  - In IDLE, clocks are stopped and the FIFO keeps accepting data until full.
- BCLK: div_cnt counts 0..BCLK_DIV-1; at the terminal count bclk toggles. A falling edge is a toggle while bclk=1.
- On each falling edge in RUN:
  - sdata <= shreg MSB; shreg shifts left; bit_cnt increments.
  - lrclk <= 1 when the new bit_cnt == AUDIO_WIDTH.
- Frame wrap: the falling edge where bit_cnt = 2*AUDIO_WIDTH-1.
  - sdata <= right LSB; bit_cnt <= 0; lrclk <= 0.
  - Pop the next sample into shreg. If the FIFO is empty, load zero and pulse underrun.
- The result is I2S one-bit delay: each channel MSB appears one BCLK after its LRCLK transition.
- All I2S outputs are registered, glitch-free, and change only on aclk edges.

## Timing
- BCLK period = 2*BCLK_DIV aclk. Frame = 2*AUDIO_WIDTH*2*BCLK_DIV aclk (default 256).
- Data, lrclk, and sdata change only on BCLK falling edges and are stable across the rising edge.
- Latency:
  - First beat into an empty IDLE FIFO with tx_en=1: the pop happens 1 aclk after the push completes.
  - Left MSB is on sdata 2*BCLK_DIV aclk after the pop.
- tready drops in the cycle after the push that fills the FIFO. It rises in the cycle after a pop from full.
- Reset mid-frame: all state returns to reset values on the next aclk edge. The FIFO is flushed and any partial frame is discarded.
- tx_en deasserted mid-frame: the frame completes, then the block goes IDLE. Re-asserting tx_en before the wrap cancels the stop.
- Underrun does not stop RUN; framing continues uninterrupted.

## Configuration
- I2S_TX_HOLD_LAST_EN:
  - Defined: on underrun, shreg reloads the last successfully popped sample (repeat-last). underrun still pulses.
  - Undefined: zeros are loaded.
  - The last-sample register resets to 0 in both builds.

## Structure
- Shared package audio_pkg holds:
  - state encoding constants (ST_IDLE, ST_RUN);
  - the channel slice positions (LEFT_LSB=0, RIGHT_LSB=16);
  - a clog2 helper for FIFO pointer width.
- Sub-module sample_fifo (sync FIFO, DEPTH, WIDTH=32, full/empty, show-ahead read) is used by this block.

## Test plan
- Reset, BCLK_DIV=4: push 0xA5A5_1234, tx_en=1 → lrclk low for 16 BCLK. sdata bits 1..16 = 0x1234 MSB first; bits 17..32 = 0xA5A5. bclk period 8 aclk.
- Continuous stream of 8 ramp samples → no underrun; every frame 256 aclk; the right LSB appears on the first slot of the next frame.
- FIFO empty after 1 sample, tx_en=1 → underrun pulses once per frame. sdata is all zero, or repeats the sample when I2S_TX_HOLD_LAST_EN is defined.
- m-side backpressure: push 6 beats back-to-back with FIFO_DEPTH=4 while IDLE → tready low after the 4th accepted beat. No data is lost once RUN starts, and order is preserved.
- tx_en dropped at bit 10 → frame completes at the wrap, then bclk/lrclk/sdata go to 0 and 1 sample remains in the FIFO.
- aresetn asserted mid-frame → all outputs 0 next cycle, FIFO empty, tready 1 after release.
